riscv_id_ex: RTL



---
 rtl/riscv_id_ex_if.sv | 55 +++++
 rtl/riscv_id_ex.sv | 118 +++++++++++
 2 files changed

// File: rtl/riscv_id_ex_if.sv
// Signal bundle between decode, execute and the forwarding sources of the ID/EX register.
// The master drives the decode/forwarding inputs; the slave (the pipeline register) drives EX outputs.
interface riscv_id_ex_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic            i_id_valid;
  logic            i_id_re1;
  logic            i_id_re2;
  logic [4:0]      i_id_rs1;
  logic [4:0]      i_id_rs2;
  logic [4:0]      i_id_rd;
  logic            i_id_we;
  logic            i_id_is_load;
  logic [XLEN-1:0] i_id_imm;
  logic [XLEN-1:0] i_id_pc;
  logic [OPW-1:0]  i_id_alu_op;
  logic            i_flush;
  logic [XLEN-1:0] i_rf_rdata1;
  logic [XLEN-1:0] i_rf_rdata2;
  logic            i_mem_we;
  logic [4:0]      i_mem_rd;
  logic [XLEN-1:0] i_mem_wdata;
  logic            i_wb_we;
  logic [4:0]      i_wb_rd;
  logic [XLEN-1:0] i_wb_wdata;
  logic            o_stall;
  logic            o_ex_valid;
  logic            o_ex_we;
  logic            o_ex_is_load;
  logic [4:0]      o_ex_rd;
  logic [XLEN-1:0] o_ex_imm;
  logic [XLEN-1:0] o_ex_pc;
  logic [OPW-1:0]  o_ex_alu_op;
  logic [XLEN-1:0] o_ex_op1;
  logic [XLEN-1:0] o_ex_op2;

  modport master (
    output i_id_valid, i_id_re1, i_id_re2, i_id_rs1, i_id_rs2, i_id_rd, i_id_we,
           i_id_is_load, i_id_imm, i_id_pc, i_id_alu_op, i_flush,
           i_rf_rdata1, i_rf_rdata2, i_mem_we, i_mem_rd, i_mem_wdata,
           i_wb_we, i_wb_rd, i_wb_wdata,
    input  o_stall, o_ex_valid, o_ex_we, o_ex_is_load, o_ex_rd, o_ex_imm,
           o_ex_pc, o_ex_alu_op, o_ex_op1, o_ex_op2
  );

  modport slave (
    input  i_id_valid, i_id_re1, i_id_re2, i_id_rs1, i_id_rs2, i_id_rd, i_id_we,
           i_id_is_load, i_id_imm, i_id_pc, i_id_alu_op, i_flush,
           i_rf_rdata1, i_rf_rdata2, i_mem_we, i_mem_rd, i_mem_wdata,
           i_wb_we, i_wb_rd, i_wb_wdata,
    output o_stall, o_ex_valid, o_ex_we, o_ex_is_load, o_ex_rd, o_ex_imm,
           o_ex_pc, o_ex_alu_op, o_ex_op1, o_ex_op2
  );
endinterface

// File: rtl/riscv_id_ex.sv
// ID/EX pipeline register: captures decoded fields, detects load-use hazards and
// resolves EX operands from MEM, WB, a latched previous WB write, or register-file data.
module riscv_id_ex #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  riscv_id_ex_if.slave     bus
);

  logic            r_valid;
  logic            r_we;
  logic            r_is_load;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_pc;
  logic [OPW-1:0]  r_alu_op;
  logic            r_re1;
  logic            r_re2;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic            r_late_we;
  logic [4:0]      r_late_rd;
  logic [XLEN-1:0] r_late_data;

  logic                 w_stall_raw;
  logic                 w_bubble;
  logic [1:0]           w_re;
  logic [1:0][4:0]      w_rs;
  logic [1:0][XLEN-1:0] w_rf;

  assign w_stall_raw = r_valid & r_is_load & r_we & (r_rd != 5'd0) & bus.i_id_valid &
                       ((bus.i_id_re1 & (bus.i_id_rs1 == r_rd)) |
                        (bus.i_id_re2 & (bus.i_id_rs2 == r_rd)));
  // A flush squashes the consumer, so there is nothing left to hold upstream.
  assign bus.o_stall = w_stall_raw & ~bus.i_flush;
  assign w_bubble    = bus.i_flush | w_stall_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_we        <= 1'b0;
      r_is_load   <= 1'b0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_alu_op    <= '0;
      r_re1       <= 1'b0;
      r_re2       <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_late_we   <= 1'b0;
      r_late_rd   <= '0;
      r_late_data <= '0;
    end else begin
      // Covers a WB write landing in the same cycle the register file was read.
      r_late_we   <= bus.i_wb_we;
      r_late_rd   <= bus.i_wb_rd;
      r_late_data <= bus.i_wb_wdata;
      if (w_bubble) begin
        r_valid   <= 1'b0;
        r_we      <= 1'b0;
        r_is_load <= 1'b0;
        r_re1     <= 1'b0;
        r_re2     <= 1'b0;
      end else begin
        r_valid   <= bus.i_id_valid;
        r_we      <= bus.i_id_we & bus.i_id_valid;
        r_is_load <= bus.i_id_is_load & bus.i_id_valid;
        r_rd      <= bus.i_id_rd;
        r_imm     <= bus.i_id_imm;
        r_pc      <= bus.i_id_pc;
        r_alu_op  <= bus.i_id_alu_op;
        r_re1     <= bus.i_id_re1;
        r_re2     <= bus.i_id_re2;
        r_rs1     <= bus.i_id_rs1;
        r_rs2     <= bus.i_id_rs2;
      end
    end
  end

  assign w_re = {r_re2, r_re1};
  assign w_rs = {r_rs2, r_rs1};
  assign w_rf = {bus.i_rf_rdata2, bus.i_rf_rdata1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [XLEN-1:0] w_op;
      always_comb begin
        w_op = bus.i_rf_rdata1 & '0;
        if (!w_re[gi] || (w_rs[gi] == 5'd0)) begin
          w_op = '0;
        end else if (bus.i_mem_we && (bus.i_mem_rd == w_rs[gi])) begin
          w_op = bus.i_mem_wdata;
        end else if (bus.i_wb_we && (bus.i_wb_rd == w_rs[gi])) begin
          w_op = bus.i_wb_wdata;
        end else if (r_late_we && (r_late_rd == w_rs[gi])) begin
          w_op = r_late_data;
        end else begin
          w_op = w_rf[gi];
        end
      end
    end
  endgenerate

  assign bus.o_ex_valid   = r_valid;
  assign bus.o_ex_we      = r_we;
  assign bus.o_ex_is_load = r_is_load;
  assign bus.o_ex_rd      = r_rd;
  assign bus.o_ex_imm     = r_imm;
  assign bus.o_ex_pc      = r_pc;
  assign bus.o_ex_alu_op  = r_alu_op;
  assign bus.o_ex_op1     = g_opnd[0].w_op;
  assign bus.o_ex_op2     = g_opnd[1].w_op;

endmodule
